// File: rtl/arbitro_rr_pkg.sv
// Shared constants and index type for the transaction-layer round-robin arbiter.
package arbitro_rr_pkg;

  localparam int unsigned NUM_FIFOS      = 4;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned DATA_WIDTH_DEF = 6;
  localparam int unsigned DEST_MSB       = DATA_WIDTH_DEF - 1;
  localparam int unsigned DEST_LSB       = DATA_WIDTH_DEF - IDX_W;

  typedef logic [IDX_W-1:0] fifo_idx_t;

  function automatic logic [NUM_FIFOS-1:0] onehot(input fifo_idx_t idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// FIFO-side signal bundle of the arbiter: input FIFO heads/flags and output FIFO strobes/bus.
interface arbitro_rr_if
  import arbitro_rr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 6
);

  logic [NUM_FIFOS-1:0]  empty_in;
  logic [DATA_WIDTH-1:0] data_in_0;
  logic [DATA_WIDTH-1:0] data_in_1;
  logic [DATA_WIDTH-1:0] data_in_2;
  logic [DATA_WIDTH-1:0] data_in_3;
  logic [NUM_FIFOS-1:0]  almost_full_out;
  logic [NUM_FIFOS-1:0]  pop_in;
  logic [NUM_FIFOS-1:0]  push_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  idle;

  modport master (
    input  empty_in, data_in_0, data_in_1, data_in_2, data_in_3, almost_full_out,
    output pop_in, push_out, data_out, idle
  );

  modport slave (
    output empty_in, data_in_0, data_in_1, data_in_2, data_in_3, almost_full_out,
    input  pop_in, push_out, data_out, idle
  );

endinterface

// File: rtl/arbitro_rr_rr_selector.sv
// Combinational round-robin pick: first eligible input after last_grant, wrapping mod 4.
module rr_selector
  import arbitro_rr_pkg::*;
(
  input  logic [NUM_FIFOS-1:0] eligible,
  input  fifo_idx_t            last_grant,
  output logic                 grant_valid,
  output fifo_idx_t            grant_idx
);

  always_comb begin
    fifo_idx_t cand;
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    cand        = last_grant;
    // Offset 4 wraps back onto last_grant itself, so it is considered last.
    for (int unsigned k = 1; k <= NUM_FIFOS; k++) begin
      cand = last_grant + fifo_idx_t'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin mover from 4 input FIFOs to 4 destination-addressed output FIFOs,
// one combinational pop per cycle and a registered push one cycle later.
module arbitro_rr #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned NUM_FIFOS  = 4
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          enable,
  arbitro_rr_if.master  bus
);

  import arbitro_rr_pkg::IDX_W;
  import arbitro_rr_pkg::fifo_idx_t;
  import arbitro_rr_pkg::onehot;

  logic [DATA_WIDTH-1:0] data_arr [NUM_FIFOS];
  fifo_idx_t             dest     [NUM_FIFOS];
  logic [NUM_FIFOS-1:0]  eligible;
  logic                  grant_valid;
  fifo_idx_t             grant_idx;
  fifo_idx_t             last_grant;
  logic [NUM_FIFOS-1:0]  push_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign data_arr[0] = bus.data_in_0;
  assign data_arr[1] = bus.data_in_1;
  assign data_arr[2] = bus.data_in_2;
  assign data_arr[3] = bus.data_in_3;

  always_comb begin
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      dest[i]     = data_arr[i][DATA_WIDTH-1 -: IDX_W];
      eligible[i] = enable && !bus.empty_in[i] && !bus.almost_full_out[dest[i]];
    end
  end

  rr_selector u_sel (
    .eligible    (eligible),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_grant <= fifo_idx_t'(NUM_FIFOS - 1);
      push_q     <= '0;
      data_q     <= '0;
    end else if (grant_valid) begin
      last_grant <= grant_idx;
      push_q     <= onehot(dest[grant_idx]);
      data_q     <= data_arr[grant_idx];
    end else begin
      push_q     <= '0;
    end
  end

  // Pop is masked during reset because the eligibility path is purely combinational.
  assign bus.pop_in   = (grant_valid && rst_l) ? onehot(grant_idx) : '0;
  assign bus.push_out = push_q;
  assign bus.data_out = data_q;
  assign bus.idle     = (&bus.empty_in) && (push_q == '0);

endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Round-robin arbiter for the transaction layer. It moves words from 4 input FIFOs to 4 output FIFOs, choosing the output FIFO from the destination field of each word.
- It pops at most one input FIFO per cycle and pushes the word to the selected output FIFO one cycle later.
- It honours almost-full backpressure from the output FIFOs.
- It reports idle to the layer FSM. The pop/push strobes it produces are what the output-side word counters observe.

Parameters:
- DATA_WIDTH, 6, word width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination index 0..3.
- NUM_FIFOS, 4, number of input and output FIFOs. This value is fixed at 4; other values are unsupported.

Ports:
- clk  input  1  clock, rising edge
- rst_l  input  1  reset, asynchronous, active-low
- enable  input  1  from FSM; high only in the ACTIVE state
- empty_in  input  4  empty flags of input FIFOs 0..3
- data_in_0..data_in_3  input  DATA_WIDTH each  head word of input FIFO i (first-word fall-through; valid when empty_in[i]=0)
- almost_full_out  input  4  almost-full flags of output FIFOs 0..3
- pop_in  output  4  one-hot pop to input FIFOs (combinational)
- push_out  output  4  one-hot push to output FIFOs (registered)
- data_out  output  DATA_WIDTH  word bus shared by all output FIFOs (registered)
- idle  output  1  no input data and no push pending

Behaviour:
- Reset (rst_l=0, asynchronous): push_out=0, data_out=0, last_grant=3, pending=0. idle=1 whenever all empty_in=1. pop_in=0 while rst_l=0.
- Eligibility: input i is eligible when all of the following hold:
  - enable=1
  - empty_in[i]=0
  - almost_full_out[dest_i]=0, where dest_i is the top 2 bits of data_in_i.
- Selection:
  - Search order is last_grant+1, +2, +3, +4, mod 4. The first eligible input wins.
  - If nothing is eligible, there is no grant.
  - An input whose destination is almost full is skipped, not waited on; no head-of-line stall across inputs.
- Cycle t, grant to i:
  - pop_in = one-hot i, combinationally in the same cycle.
  - last_grant <= i at the clk edge.
- Cycle t+1:
  - push_out = one-hot dest_i.
  - data_out = the data_in_i word sampled at the t edge.
  - Latency pop→push is exactly 1 cycle.
- Without a grant at t: push_out=0 at t+1. data_out holds its last value.
- Throughput: one word per cycle sustained. Back-to-back grants to different or the same inputs are allowed.
- Backpressure margin: output FIFOs must raise almost_full with at least 1 free slot of margin, so one in-flight push is always absorbed. The arbiter does not re-check almost_full at push time.
- enable falling: no new pops from that cycle on. A word already popped is still pushed in the next cycle.
- Pointer: last_grant is unchanged while there is no grant.
- idle = &empty_in && (push_out==0). Combinational from registered and input signals.
- Reset mid-transfer: a word popped in the cycle before reset is dropped (push_out forced 0 asynchronously). The layer reset also clears all FIFOs, so this is accepted.
- Simultaneous events: several eligible inputs resolve by round-robin only. Two inputs with the same destination cannot collide, because only one pop happens per cycle.

Decomposition:
- Shared package holds:
  - NUM_FIFOS = 4
  - IDX_W = 2
  - DEST_MSB / DEST_LSB field positions
  - a typedef for the 2-bit FIFO index
- One combinational sub-module, rr_selector:
  - inputs: eligible[3:0], last_grant[1:0]
  - outputs: grant_valid, grant_idx[1:0]
- arbitro_rr holds:
  - the eligibility logic
  - the last_grant register
  - the push/data pipeline register

Test Plan:
- Reset: rst_l=0 with all empty_in=0 → pop_in=0000, push_out=0000, data_out=0. After release with empty_in=1111 → idle=1.
- Single transfer: empty_in=1011, data_in_2=6'b01_0101, enable=1 → cycle t: pop_in=0100. Cycle t+1: push_out=0010, data_out=6'h15. Cycle t+2: push_out=0000, idle=1 once empty_in=1111.
- Round-robin: all inputs non-empty, all destinations 0, almost_full_out=0 → pop_in sequence 0001,0010,0100,1000,0001. push_out=0001 every cycle from t+1.
- Backpressure skip: data_in_0 dest 3 with almost_full_out[3]=1, data_in_1 dest 2, last_grant=3 → pop_in=0010, then push_out=0100. Input 0 is popped the cycle after almost_full_out[3] falls.
- Enable gating: enable=0 with data present → pop_in=0000, idle=0, last_grant unchanged. Re-enable → grant resumes at last_grant+1.
- Async reset mid-transfer: pop at t, rst_l low before the t+1 edge → push_out=0000 immediately. That word is never pushed; data_out=0.
